fc_layer_ctrl: RTL and testbench
================================

# fc_layer_ctrl

Sequencer that runs one shared single-neuron FC engine (30-input dot product plus bias, 2-cycle compute, one-cycle finish pulse) over all NUM_OUT neurons of a layer. Per neuron it addresses the weight/bias ROM, launches the engine, and captures the 32-bit result. Each result is streamed out, and the layer's argmax is tracked. The block sits between the feature buffer/ROM and the gesture-classification output.

## Interface
- NUM_OUT, 10: number of output neurons (2..16).
- IDX_W, 4: index width; 2^IDX_W ≥ NUM_OUT.
- WAIT_MAX, 15: watchdog limit in cycles spent in S_WAIT.

Ports:
- i_clk  in  1  sole clock, rising edge.
- i_rst_n  in  1  one clock; reset is asynchronous and active-high (asserted = 1 despite the name; shared with the FC engine).
- i_start  in  1  launch one layer pass; sampled only in S_IDLE.
- o_busy  out  1  high in every state except S_IDLE.
- o_rom_addr  out  IDX_W  neuron index to weight/bias ROM (1-cycle read latency).
- o_fc_start  out  1  one-cycle launch pulse to the FC engine.
- i_fc_output  in  32  signed engine result; valid while i_fc_finished=1.
- i_fc_finished  in  1  engine completion pulse.
- o_out_valid  out  1  one-cycle pulse per captured neuron.
- o_out_idx  out  IDX_W  index of the captured neuron.
- o_out_value  out  32  signed captured value (post-ReLU when enabled).
- o_argmax  out  IDX_W  index of the maximum value; valid with o_done.
- o_max_value  out  32  maximum value.
- o_done  out  1  one-cycle pulse at successful end of pass.
- o_error  out  1  sticky watchdog flag; cleared by the next accepted i_start.

## Operation
- States: S_IDLE, S_FETCH, S_KICK, S_WAIT, S_STORE, S_DONE.
- S_IDLE: on i_start, set idx=0, clear o_error, go to S_FETCH.
- S_FETCH: o_rom_addr=idx; this state absorbs the ROM latency. Go to S_KICK.
- S_KICK: o_fc_start=1 for exactly this cycle. Go to S_WAIT and clear the wait counter.
- S_WAIT: on i_fc_finished=1, register i_fc_output and go to S_STORE. Otherwise increment the counter. If the counter reaches WAIT_MAX, set o_error and return to S_IDLE; no o_done is issued.
- S_STORE: o_out_valid=1, with o_out_idx=idx and o_out_value=the captured value.
  - Argmax update: neuron 0 initializes max/argmax unconditionally. Later neurons update max/argmax only if the value is strictly greater (signed), so ties keep the lowest index.
  - If idx==NUM_OUT-1, go to S_DONE. Otherwise increment idx and go to S_FETCH.
  - This state is also the cycle in which the engine returns to idle, so the next o_fc_start can never fall in the engine's done state.
- S_DONE: o_done=1. Go to S_IDLE.
- o_rom_addr holds idx from S_FETCH through S_STORE, so the ROM data stays stable during the engine's compute cycle.
- i_start is ignored outside S_IDLE. i_fc_finished is ignored outside S_WAIT.
- The value compare is a full 32-bit signed compare; there is no saturation or rescaling.

## Timing
- Reset values: o_busy, o_fc_start, o_out_valid, o_done, o_error = 0; o_rom_addr, o_out_idx, o_argmax = 0; o_out_value, o_max_value = 0; state = S_IDLE.
- Per neuron: 5 cycles (FETCH, KICK, WAIT×2, STORE), given the engine's finish 2 cycles after the start pulse is sampled.
- Edge t samples i_start. o_done is high in cycle t+5·NUM_OUT+1 (cycles numbered so that S_FETCH is cycle t+1). For NUM_OUT=10, o_done is in cycle t+51.
- o_argmax and o_max_value are final from the o_done cycle and hold until the next pass reaches neuron 0's S_STORE.
- Reset mid-pass: all registers return to their reset values immediately. No o_done or o_out_valid follows. A new pass needs a fresh i_start.
- i_start asserted in the same cycle as o_done is ignored, because the block is not yet in S_IDLE.

## Configuration
- FC_LAYER_RELU_EN defined: the captured value is clamped to 0 when negative, before the stream output and before the argmax compare.
- FC_LAYER_RELU_EN undefined: raw signed values pass through unchanged. All other behaviour and timing are identical in both cases.

## Test plan
- NUM_OUT=10, engine model returns value k·100 for neuron k, one pass → ten o_out_valid pulses with idx 0..9; o_argmax=9, o_max_value=900; o_done at t+51.
- Values {-5,7,7,3,...,-1} → o_argmax=1 (tie keeps lowest index), o_max_value=7.
- All values negative, ({-50,-3,-80,...}) → without RELU: o_argmax=1, o_max_value=-3. With FC_LAYER_RELU_EN: every o_out_value=0, o_argmax=0, o_max_value=0.
- Engine never asserts finished → o_error=1 after 15 WAIT cycles, no o_done, o_busy=0. Next i_start clears o_error.
- Reset asserted during neuron 4's S_WAIT → all outputs return to reset values the same cycle. i_start pulses while busy and stray i_fc_finished pulses in S_IDLE cause no state change.

Source files
------------

// File: rtl/fc_layer_ctrl.sv
// fc_layer_ctrl: sequences one shared single-neuron FC engine over NUM_OUT neurons, streams each result, tracks argmax.
// Latency: 5 cycles per neuron with a 2-cycle engine; o_done is high start_edge + 5*NUM_OUT + 1 cycles.
// Backpressure: none; i_start accepted only in S_IDLE, engine stalls bounded by WAIT_MAX (sticky o_error).
// Optional feature: define FC_LAYER_RELU_EN to clamp negative engine results to zero before streaming and argmax.
module fc_layer_ctrl #(
  parameter int NUM_OUT  = 10,
  parameter int IDX_W    = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  output logic                    o_busy,
  output logic [IDX_W-1:0]        o_rom_addr,
  output logic                    o_fc_start,
  input  logic signed [31:0]      i_fc_output,
  input  logic                    i_fc_finished,
  output logic                    o_out_valid,
  output logic [IDX_W-1:0]        o_out_idx,
  output logic signed [31:0]      o_out_value,
  output logic [IDX_W-1:0]        o_argmax,
  output logic signed [31:0]      o_max_value,
  output logic                    o_done,
  output logic                    o_error
);

  localparam int               CNT_W    = $clog2(WAIT_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);
  // The counter is compared before it increments, so the last allowed WAIT cycle sees WAIT_MAX-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_KICK  = 3'd2,
    S_WAIT  = 3'd3,
    S_STORE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [IDX_W-1:0]          idx;
  logic [CNT_W-1:0]          wait_cnt;
  logic signed [31:0]        cap_value;
  logic signed [31:0]        fc_value;
  logic [IDX_W-1:0]          argmax_q;
  logic signed [31:0]        max_q;
  logic                      error_q;
  logic                      start_acc;
  logic                      wait_expired;
  logic                      last_neuron;
  logic                      max_update;

  // Engine result as it will be captured: optionally clamped at zero.
`ifdef FC_LAYER_RELU_EN
  assign fc_value = i_fc_output[31] ? 32'sd0 : i_fc_output;
`else
  assign fc_value = i_fc_output;
`endif

  assign start_acc    = (state == S_IDLE) && i_start;
  assign wait_expired = (state == S_WAIT) && !i_fc_finished && (wait_cnt == CNT_LAST);
  assign last_neuron  = (idx == LAST_IDX);
  // Neuron 0 seeds the running max; later neurons must be strictly greater so ties keep the lower index.
  assign max_update   = (idx == '0) || (cap_value > max_q);

  assign o_rom_addr  = idx;
  assign o_out_idx   = idx;
  assign o_out_value = cap_value;
  assign o_argmax    = argmax_q;
  assign o_max_value = max_q;
  assign o_error     = error_q;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_KICK;
      S_KICK:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (i_fc_finished) begin
          state_nxt = S_STORE;
        end else if (wait_expired) begin
          state_nxt = S_IDLE;
        end
      end
      S_STORE: state_nxt = last_neuron ? S_DONE : S_FETCH;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded strobes.
  always_comb begin
    o_busy      = (state != S_IDLE);
    o_fc_start  = (state == S_KICK);
    o_out_valid = (state == S_STORE);
    o_done      = (state == S_DONE);
  end

  // Neuron index: restarts on an accepted start, advances after each store, holds through FETCH..STORE.
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      idx <= '0;
    end else if (start_acc) begin
      idx <= '0;
    end else if ((state == S_STORE) && !last_neuron) begin
      idx <= idx + 1'b1;
    end
  end

  // Watchdog counter: cleared at the engine launch, counts WAIT cycles without a finish.
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      wait_cnt <= '0;
    end else if (state == S_KICK) begin
      wait_cnt <= '0;
    end else if ((state == S_WAIT) && !i_fc_finished && !wait_expired) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Capture the engine result on its finish pulse; finishes outside S_WAIT are ignored.
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      cap_value <= '0;
    end else if ((state == S_WAIT) && i_fc_finished) begin
      cap_value <= fc_value;
    end
  end

  // Running argmax, updated while the captured value is presented on the stream.
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      argmax_q <= '0;
      max_q    <= '0;
    end else if ((state == S_STORE) && max_update) begin
      argmax_q <= idx;
      max_q    <= cap_value;
    end
  end

  // Sticky watchdog flag, cleared only by the next accepted start.
  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      error_q <= 1'b0;
    end else if (start_acc) begin
      error_q <= 1'b0;
    end else if (wait_expired) begin
      error_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// tb_fc_layer_ctrl: randomized and directed passes against a behavioural layer model.
// Engine model returns a per-neuron value a configurable number of cycles after each launch.
// All outputs sampled on the falling edge; inputs driven on the falling edge.
module tb_fc_layer_ctrl;

  localparam int NUM_OUT  = 10;
  localparam int IDX_W    = 4;
  localparam int WAIT_MAX = 15;

  logic               i_clk = 1'b0;
  logic               i_rst_n;
  logic               i_start;
  logic               o_busy;
  logic [IDX_W-1:0]   o_rom_addr;
  logic               o_fc_start;
  logic signed [31:0] i_fc_output;
  logic               i_fc_finished;
  logic               o_out_valid;
  logic [IDX_W-1:0]   o_out_idx;
  logic signed [31:0] o_out_value;
  logic [IDX_W-1:0]   o_argmax;
  logic signed [31:0] o_max_value;
  logic               o_done;
  logic               o_error;

  fc_layer_ctrl #(.NUM_OUT(NUM_OUT), .IDX_W(IDX_W), .WAIT_MAX(WAIT_MAX)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .o_busy(o_busy),
    .o_rom_addr(o_rom_addr), .o_fc_start(o_fc_start), .i_fc_output(i_fc_output),
    .i_fc_finished(i_fc_finished), .o_out_valid(o_out_valid), .o_out_idx(o_out_idx),
    .o_out_value(o_out_value), .o_argmax(o_argmax), .o_max_value(o_max_value),
    .o_done(o_done), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Stimulus-owned model state.
  int  vals [16];
  int  exp_val [NUM_OUT];
  int  exp_argmax, exp_max;
  int  start_cyc = -100, exp_done_cyc = -100;
  int  pass_no = 0;
  bit  chk_en = 1'b0;
  bit  eng_en = 1'b1, eng_flush = 1'b0, stray_fin = 1'b0;
  int  eng_lat = 2;

  // Compare-owned state.
  int  cur_pass = 0, out_cnt = 0, kick_idx = 0, done_cnt = 0, last_done_cyc = 0;

  // Engine-owned state.
  int  eng_rem = 0;
  int  eng_val = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int relu(input int v);
`ifdef FC_LAYER_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Layer model: stream is relu(vals[k]) in order; argmax is the first index of the maximum.
  task automatic prep_model();
    for (int k = 0; k < NUM_OUT; k++) begin
      exp_val[k] = relu(vals[k]);
      if (k == 0 || exp_val[k] > exp_max) begin
        exp_max    = exp_val[k];
        exp_argmax = k;
      end
    end
  endtask

  task automatic set_vals(input int t [NUM_OUT]);
    for (int k = 0; k < NUM_OUT; k++) vals[k] = t[k];
  endtask

  task automatic check_rst(input string p);
    chk({p, "_busy"},      o_busy, 0);
    chk({p, "_fc_start"},  o_fc_start, 0);
    chk({p, "_out_valid"}, o_out_valid, 0);
    chk({p, "_done"},      o_done, 0);
    chk({p, "_error"},     o_error, 0);
    chk({p, "_rom_addr"},  o_rom_addr, 0);
    chk({p, "_out_idx"},   o_out_idx, 0);
    chk({p, "_argmax"},    o_argmax, 0);
    chk({p, "_out_value"}, o_out_value, 0);
    chk({p, "_max_value"}, o_max_value, 0);
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // Engine model: finish pulse eng_lat cycles after the launch, carrying vals[rom_addr].
  always @(negedge i_clk) begin
    i_fc_finished = 1'b0;
    i_fc_output   = $urandom;
    if (eng_flush) eng_rem = 0;
    if (eng_rem > 0) begin
      eng_rem--;
      if (eng_rem == 0) begin
        i_fc_finished = 1'b1;
        i_fc_output   = eng_val;
      end
    end
    if (eng_en && o_fc_start) begin
      eng_rem = eng_lat;
      eng_val = vals[o_rom_addr];
    end
    if (stray_fin) i_fc_finished = 1'b1;
  end

  // Compare process: checks every cycle of a pass against the model.
  always @(negedge i_clk) begin
    if (chk_en) begin
      if (cur_pass != pass_no) begin
        cur_pass = pass_no;
        out_cnt  = 0;
        kick_idx = 0;
      end
      chk("busy", o_busy, (cyc > start_cyc && cyc <= exp_done_cyc) ? 1 : 0);
      if (cyc == start_cyc + 1) chk("error_cleared", o_error, 0);
      if (o_fc_start) begin
        chk("kick_addr", o_rom_addr, kick_idx);
        kick_idx++;
      end
      if (o_out_valid) begin
        if (out_cnt < NUM_OUT) begin
          chk("out_idx", o_out_idx, out_cnt);
          chk("out_value", o_out_value, exp_val[out_cnt]);
        end else begin
          chk("extra_valid", o_out_valid, 0);
        end
        out_cnt++;
      end
      if (o_done) begin
        chk("done_cycle", cyc, exp_done_cyc);
        chk("done_out_cnt", out_cnt, NUM_OUT);
        chk("done_argmax", o_argmax, exp_argmax);
        chk("done_max", o_max_value, exp_max);
        chk("done_error", o_error, 0);
        done_cnt++;
        last_done_cyc = cyc;
      end
    end
  end

  // One full pass; optionally hold i_start high up to and including the o_done cycle.
  task automatic run_pass(input bit hold_start);
    int guard;
    int done_before;
    prep_model();
    done_before = done_cnt;
    @(negedge i_clk);
    start_cyc    = cyc;
    exp_done_cyc = cyc + NUM_OUT * (3 + eng_lat) + 1;
    pass_no++;
    i_start = 1'b1;
    guard = 0;
    while (cyc < exp_done_cyc + 1 && guard < 1000) begin
      @(negedge i_clk);
      guard++;
      i_start = hold_start && (cyc <= exp_done_cyc);
    end
    i_start = 1'b0;
    chk("pass_done_count", done_cnt - done_before, 1);
    guard = 0;
    while (o_busy && guard < 300) begin
      @(negedge i_clk);
      guard++;
    end
    @(negedge i_clk);
  endtask

  initial begin
    int s, guard, viol;
    bit seen_done;
    i_rst_n = 1'b0;
    i_start = 1'b0;
    #2 i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    check_rst("rst");
    i_rst_n = 1'b0;
    @(negedge i_clk);
    chk_en = 1'b1;

    // k*100 per neuron, nominal 2-cycle engine.
    for (int k = 0; k < NUM_OUT; k++) vals[k] = k * 100;
    eng_lat = 2;
    run_pass(1'b0);
    chk("lit_ramp_argmax", o_argmax, 9);
    chk("lit_ramp_max", o_max_value, 900);
    chk("lit_ramp_latency", last_done_cyc - start_cyc, 51);

    // Ties keep the lowest index.
    set_vals('{-5, 7, 7, 3, 0, 1, 2, -9, 6, -1});
    run_pass(1'b1);
    chk("lit_tie_argmax", o_argmax, 1);
    chk("lit_tie_max", o_max_value, 7);

    // All negative.
    set_vals('{-50, -3, -80, -7, -100, -9, -4, -60, -33, -20});
    run_pass(1'b0);
`ifdef FC_LAYER_RELU_EN
    chk("lit_neg_argmax", o_argmax, 0);
    chk("lit_neg_max", o_max_value, 0);
`else
    chk("lit_neg_argmax", o_argmax, 1);
    chk("lit_neg_max", o_max_value, -3);
`endif

    // Slowest engine the watchdog tolerates: finish in the last allowed WAIT cycle.
    for (int k = 0; k < NUM_OUT; k++) vals[k] = int'($urandom_range(0, 2000)) - 1000;
    eng_lat = WAIT_MAX;
    run_pass(1'b0);
    chk("lit_slow_latency", last_done_cyc - start_cyc, NUM_OUT * (3 + WAIT_MAX) + 1);

    // Watchdog: engine never finishes.
    chk_en = 1'b0;
    eng_en = 1'b0;
    @(negedge i_clk);
    i_start = 1'b1;
    s = cyc;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("wd_busy", o_busy, 1);
    seen_done = 1'b0;
    guard = 0;
    while (o_busy && guard < 100) begin
      @(negedge i_clk);
      guard++;
      if (o_done) seen_done = 1'b1;
    end
    chk("wd_idle_at", cyc - s, 18);
    chk("wd_error", o_error, 1);
    chk("wd_no_done", seen_done, 0);
    chk("wd_busy_low", o_busy, 0);
    repeat (3) @(negedge i_clk);
    chk("wd_error_sticky", o_error, 1);
    eng_en  = 1'b1;
    eng_lat = 2;
    chk_en  = 1'b1;
    run_pass(1'b0);

    // Reset during neuron 4's first WAIT cycle.
    chk_en = 1'b0;
    set_vals('{5, 10, 20, 30, 40, 1, 2, 3, 4, 6});
    @(negedge i_clk);
    i_start = 1'b1;
    s = cyc;
    @(negedge i_clk);
    i_start = 1'b0;
    guard = 0;
    while (cyc < s + 23 && guard < 100) begin
      @(negedge i_clk);
      guard++;
    end
    chk("pre_rst_busy", o_busy, 1);
    chk("pre_rst_addr", o_rom_addr, 4);
    chk("pre_rst_max", o_max_value, 30);
    #1 i_rst_n = 1'b1;
    eng_flush = 1'b1;
    #1 check_rst("midrst");
    repeat (2) @(negedge i_clk);
    i_rst_n   = 1'b0;
    eng_flush = 1'b0;
    viol = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge i_clk);
      stray_fin = (i % 3 == 0);
      if (o_busy || o_out_valid || o_done || o_fc_start) viol++;
    end
    stray_fin = 1'b0;
    @(negedge i_clk);
    chk("post_rst_quiet", viol, 0);
    chk_en = 1'b1;

    // Randomized passes: small values force ties, wide values exercise the full signed range.
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if ($urandom_range(0, 1) == 1) vals[k] = int'($urandom);
        else vals[k] = int'($urandom_range(0, 8)) - 4;
      end
      eng_lat = $urandom_range(1, 6);
      run_pass(r % 2 == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
